// File: rtl/if_id_stage_ctrl_pkg.sv
// Shared constants and types for the IF/ID register and ID hazard control.
// Opcode/funct values, FSM state encoding and the default NOP word.
package if_id_stage_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUNCT_JR = 6'b001000;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    RUN,
    BR_WAIT,
    DRAIN,
    HALT
  } state_t;

endpackage

// File: rtl/if_id_stage_ctrl_if.sv
// Fetch-side inputs and ID-side outputs of the IF/ID stage.
// master drives fetch/EX/MEM info, slave is the IF/ID stage.
interface if_id_stage_ctrl_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] PC_add4_in;
  logic [WIDTH-1:0] inst_in;
  logic             fin_sign;
  logic             Flush;
  logic             EX_MemRead;
  logic             EX_RegWrite;
  logic [4:0]       EX_dst;
  logic             MEM_MemRead;
  logic [4:0]       MEM_dst;
  logic [WIDTH-1:0] PC_add4_out;
  logic [WIDTH-1:0] inst_out;
  logic             valid_out;
  logic             Stall;
  logic             waiting;
  logic             bubble;
  logic             halt;

  modport master (
    output PC_add4_in, inst_in, fin_sign, Flush,
    output EX_MemRead, EX_RegWrite, EX_dst,
    output MEM_MemRead, MEM_dst,
    input  PC_add4_out, inst_out, valid_out,
    input  Stall, waiting, bubble, halt
  );

  modport slave (
    input  PC_add4_in, inst_in, fin_sign, Flush,
    input  EX_MemRead, EX_RegWrite, EX_dst,
    input  MEM_MemRead, MEM_dst,
    output PC_add4_out, inst_out, valid_out,
    output Stall, waiting, bubble, halt
  );
endinterface

// File: rtl/if_id_stage_ctrl_hazard_detect.sv
// Combinational ID-stage hazard detection on the latched instruction.
// Flags load-use, branch/jr operand hazards, and the two-cycle case.
module if_id_stage_ctrl_hazard_detect
  import if_id_stage_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        valid,
  input  logic        ex_memread,
  input  logic        ex_regwrite,
  input  logic [4:0]  ex_dst,
  input  logic        mem_memread,
  input  logic [4:0]  mem_dst,
  output logic        ld_use,
  output logic        br_hit,
  output logic        br_two
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic       uses_rs;
  logic       uses_rt;
  logic       ctl;
  logic       ex_match;
  logic       mem_match;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign funct = inst[5:0];

  // Operand usage, control-flow class and source matches ($0 never matches).
  always_comb begin
    uses_rs = !((op == OP_J) || (op == OP_JAL));
    uses_rt = (op == OP_RTYPE) || (op == OP_BEQ) ||
              (op == OP_BNE) || (op == OP_SW);
    ctl = valid && ((op == OP_BEQ) || (op == OP_BNE) ||
          ((op == OP_RTYPE) && (funct == FUNCT_JR)));
    ex_match = (ex_dst != 5'd0) &&
               ((uses_rs && (ex_dst == rs)) ||
                (uses_rt && (ex_dst == rt)));
    mem_match = (mem_dst != 5'd0) &&
                ((uses_rs && (mem_dst == rs)) ||
                 (uses_rt && (mem_dst == rt)));
    ld_use = valid && ex_memread && ex_match;
    br_two = ctl && ex_memread && ex_match;
    br_hit = ctl && ((ex_match && (ex_regwrite || ex_memread)) ||
                     (mem_match && mem_memread));
  end

endmodule

// File: rtl/if_id_stage_ctrl.sv
// IF/ID pipeline register with stall/flush/drain control.
// Hazard FSM drives Stall, waiting and bubble in the hazard cycle.
module if_id_stage_ctrl
  import if_id_stage_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DRAIN_CYCLES = 4,
  parameter logic [WIDTH-1:0] NOP_WORD     = if_id_stage_ctrl_pkg::NOP_WORD
) (
  input logic                CLOCK,
  input logic                RESET,
  if_id_stage_ctrl_if.slave  bus
);

  localparam int DW = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [DW-1:0]    dcnt_q, dcnt_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic             valid_q, valid_d;
  logic             stall, waiting, bubble;
  logic             ld_use, br_hit, br_two;

  if_id_stage_ctrl_hazard_detect u_hazard (
    .inst        (inst_q[31:0]),
    .valid       (valid_q),
    .ex_memread  (bus.EX_MemRead),
    .ex_regwrite (bus.EX_RegWrite),
    .ex_dst      (bus.EX_dst),
    .mem_memread (bus.MEM_MemRead),
    .mem_dst     (bus.MEM_dst),
    .ld_use      (ld_use),
    .br_hit      (br_hit),
    .br_two      (br_two)
  );

  // Hazard/drain FSM: next state and same-cycle stall controls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dcnt_d  = dcnt_q;
    stall   = 1'b0;
    waiting = 1'b0;
    bubble  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (br_hit) begin
          stall   = 1'b1;
          waiting = 1'b1;
          bubble  = 1'b1;
          if (br_two) begin
            state_d = BR_WAIT;
            cnt_d   = 2'd1;
          end
        end else if (ld_use) begin
          stall  = 1'b1;
          bubble = 1'b1;
        end else if (bus.fin_sign) begin
          state_d = DRAIN;
          dcnt_d  = DW'(DRAIN_CYCLES - 1);
        end
      end
      BR_WAIT: begin
        stall   = 1'b1;
        waiting = 1'b1;
        bubble  = 1'b1;
        if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (dcnt_q == '0) state_d = HALT;
        else dcnt_d = dcnt_q - 1'b1;
      end
      HALT: begin
        stall = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Register next value: drain NOP > hold on stall > flush > load.
  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (state_q == DRAIN) begin
      pc_d    = '0;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (stall) begin
      pc_d    = pc_q;
    end else if (bus.Flush) begin
      pc_d    = '0;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else if (bus.inst_in[31:0] == END_MARKER) begin
      pc_d    = bus.PC_add4_in;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      pc_d    = bus.PC_add4_in;
      inst_d  = bus.inst_in;
      valid_d = 1'b1;
    end
  end

  // State and pipeline register update.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= RUN;
      cnt_q   <= '0;
      dcnt_q  <= '0;
      pc_q    <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dcnt_q  <= dcnt_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign bus.PC_add4_out = pc_q;
  assign bus.inst_out    = inst_q;
  assign bus.valid_out   = valid_q;
  assign bus.Stall       = stall && !RESET;
  assign bus.waiting     = waiting && !RESET;
  assign bus.bubble      = bubble && !RESET;
  assign bus.halt        = (state_q == HALT);

endmodule

// File: tb/tb_if_id_stage_ctrl.sv
// Scoreboard bench for if_id_stage_ctrl: directed per-cycle vectors.
// Stimulus pushes expected cycle state; a monitor pops and compares.
module tb_if_id_stage_ctrl;

  typedef struct {
    logic [2:0]  swb;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        v;
    logic        h;
  } exp_t;

  localparam logic [31:0] ADD  = 32'h0023_1020;
  localparam logic [31:0] ADD2 = 32'h0064_2820;
  localparam logic [31:0] BEQ  = 32'h1085_0003;
  localparam logic [31:0] ADDI = 32'h2002_000A;
  localparam logic [31:0] ENDM = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc_no = 0;

  if_id_stage_ctrl_if #(.WIDTH(32)) bus ();

  if_id_stage_ctrl dut (
    .CLOCK (clk),
    .RESET (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int c,
                     input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, c, got, exp);
    end
  endtask

  task automatic cyc(
    input logic r, input logic [31:0] pc, input logic [31:0] in,
    input logic fin, input logic fl,
    input logic exmr, input logic exrw, input logic [4:0] exd,
    input logic mmr, input logic [4:0] md,
    input logic [2:0] e_swb, input logic [31:0] e_inst,
    input logic [31:0] e_pc, input logic e_v, input logic e_h);
    exp_t e;
    @(negedge clk);
    rst             = r;
    bus.PC_add4_in  = pc;
    bus.inst_in     = in;
    bus.fin_sign    = fin;
    bus.Flush       = fl;
    bus.EX_MemRead  = exmr;
    bus.EX_RegWrite = exrw;
    bus.EX_dst      = exd;
    bus.MEM_MemRead = mmr;
    bus.MEM_dst     = md;
    e.swb  = e_swb;
    e.inst = e_inst;
    e.pc   = e_pc;
    e.v    = e_v;
    e.h    = e_h;
    q.push_back(e);
  endtask

  // Monitor: one record describes the settled state of each cycle.
  initial begin
    exp_t e;
    logic [2:0] swb;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        swb = {bus.Stall, bus.waiting, bus.bubble};
        chk("swb", cyc_no, 32'(swb), 32'(e.swb));
        chk("inst_out", cyc_no, bus.inst_out, e.inst);
        chk("pc_out", cyc_no, bus.PC_add4_out, e.pc);
        chk("valid_out", cyc_no, 32'(bus.valid_out), 32'(e.v));
        chk("halt", cyc_no, 32'(bus.halt), 32'(e.h));
        cyc_no++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.PC_add4_in = '0;
    bus.inst_in = '0;
    bus.fin_sign = 1'b0;
    bus.Flush = 1'b0;
    bus.EX_MemRead = 1'b0;
    bus.EX_RegWrite = 1'b0;
    bus.EX_dst = '0;
    bus.MEM_MemRead = 1'b0;
    bus.MEM_dst = '0;
    repeat (2) @(posedge clk);
    // r  pc    inst  fin fl mr rw exd mmr md  swb     inst  pc  v h
    cyc(1, 0,  0,    0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 0);
    // load-use: lw $1 in EX, add $2,$1,$3 in ID
    cyc(0, 4,  ADD,  0, 0, 1, 0, 1, 0, 0, 3'b000, 0,    0,  0, 0);
    cyc(0, 8,  ADD2, 0, 0, 1, 0, 1, 0, 0, 3'b101, ADD,  4,  1, 0);
    cyc(0, 8,  ADD2, 0, 0, 0, 0, 0, 0, 0, 3'b000, ADD,  4,  1, 0);
    cyc(0, 12, BEQ,  0, 0, 0, 0, 0, 0, 0, 3'b000, ADD2, 8,  1, 0);
    // beq $4,$5 with lw $5 in EX: two cycles
    cyc(0, 16, BEQ,  0, 0, 1, 0, 5, 0, 0, 3'b111, BEQ,  12, 1, 0);
    cyc(0, 16, BEQ,  0, 0, 0, 0, 0, 1, 5, 3'b111, BEQ,  12, 1, 0);
    cyc(0, 16, BEQ,  0, 0, 0, 0, 0, 0, 0, 3'b000, BEQ,  12, 1, 0);
    // beq with ALU write of $4 in EX: one cycle
    cyc(0, 20, ADDI, 0, 0, 0, 1, 4, 0, 0, 3'b111, BEQ,  16, 1, 0);
    // flush
    cyc(0, 20, ADDI, 0, 1, 0, 0, 0, 0, 0, 3'b000, BEQ,  16, 1, 0);
    cyc(0, 24, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 0);
    // flush during stall is ignored
    cyc(0, 28, ADDI, 0, 1, 1, 0, 1, 0, 0, 3'b101, ADD,  24, 1, 0);
    cyc(0, 28, ADDI, 0, 0, 0, 0, 0, 0, 0, 3'b000, ADD,  24, 1, 0);
    // $0 exempt from load-use
    cyc(0, 32, ENDM, 0, 0, 1, 0, 0, 0, 0, 3'b000, ADDI, 28, 1, 0);
    // end marker plus drain to halt
    cyc(0, 32, ENDM, 1, 0, 0, 0, 0, 0, 0, 3'b000, 0,    32, 0, 0);
    cyc(0, 36, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    32, 0, 0);
    cyc(0, 36, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    0,  0, 0);
    cyc(0, 36, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    0,  0, 0);
    cyc(0, 36, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    0,  0, 0);
    cyc(0, 36, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    0,  0, 1);
    cyc(0, 40, ADDI, 0, 1, 0, 0, 0, 0, 0, 3'b100, 0,    0,  0, 1);
    cyc(1, 4,  ADD,  0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 1);
    // restart, then reset in the middle of a drain
    cyc(0, 4,  ADD,  0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 0);
    cyc(0, 8,  ENDM, 1, 0, 0, 0, 0, 0, 0, 3'b000, ADD,  4,  1, 0);
    cyc(0, 12, ADDI, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0,    8,  0, 0);
    cyc(1, 12, ADDI, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 0);
    cyc(0, 16, ADDI, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0,    0,  0, 0);
    cyc(0, 20, ADD,  0, 0, 0, 0, 0, 0, 0, 3'b000, ADDI, 16, 1, 0);
    cyc(0, 24, ADD2, 0, 0, 0, 0, 0, 0, 0, 3'b000, ADD,  20, 1, 0);
    @(negedge clk);
    #4;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_queue: got %0d pending want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
